// File: rtl/adder_share_sched.sv
// -----------------------------------------------------------------------------
// adder_share_sched
//
// Round-robin scheduler that time-shares one external combinational
// WIDTH-bit adder between two requesters. A narrow request is one pass
// through the adder on the low words. A wide request is two passes, low
// then high, with the carry registered between them. Each accepted request
// produces one registered result on a valid/ready response channel.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   rN_valid / rN_ready      request handshake, N = 0, 1 (ready is combinational)
//   rN_a, rN_b               2*WIDTH-bit operands
//   rN_cin, rN_wide          carry-in; 1 = 2*WIDTH add, 0 = WIDTH add on low words
//   add_a, add_b, add_cin    operands driven to the shared adder (0 when idle)
//   add_sum, add_cout, add_of  adder results, combinational in the same cycle
//   rsp_valid / rsp_ready    response handshake
//   rsp_id                   requester that owns the result
//   rsp_sum, rsp_cout, rsp_of  result of the most-significant pass performed
//   busy                     high in any state other than IDLE
// -----------------------------------------------------------------------------
module adder_share_sched #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               r0_valid,
    output logic               r0_ready,
    input  logic [2*WIDTH-1:0] r0_a,
    input  logic [2*WIDTH-1:0] r0_b,
    input  logic               r0_cin,
    input  logic               r0_wide,
    input  logic               r1_valid,
    output logic               r1_ready,
    input  logic [2*WIDTH-1:0] r1_a,
    input  logic [2*WIDTH-1:0] r1_b,
    input  logic               r1_cin,
    input  logic               r1_wide,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    output logic               add_cin,
    input  logic [WIDTH-1:0]   add_sum,
    input  logic               add_cout,
    input  logic               add_of,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [2*WIDTH-1:0] rsp_sum,
    output logic               rsp_cout,
    output logic               rsp_of,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        RESP
    } state_t;

    state_t               state_q, state_d;
    logic                 ptr_q, ptr_d;      // last requester granted
    logic [2*WIDTH-1:0]   a_q, a_d;
    logic [2*WIDTH-1:0]   b_q, b_d;
    logic                 cin_q, cin_d;
    logic                 wide_q, wide_d;
    logic                 id_q, id_d;
    logic [2*WIDTH-1:0]   sum_q, sum_d;
    logic                 carry_q, carry_d;  // low-pass carry feeding the high pass
    logic                 cout_q, cout_d;
    logic                 of_q, of_d;
    logic                 grant_r1;

    // The requester not granted last time has priority: with ptr_q = 1
    // (r1 last) r1 only wins when r0 is not asking, and vice versa.
    assign grant_r1 = r1_valid && (!ptr_q || !r0_valid);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d  = state_q;
        ptr_d    = ptr_q;
        a_d      = a_q;
        b_d      = b_q;
        cin_d    = cin_q;
        wide_d   = wide_q;
        id_d     = id_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        of_d     = of_q;
        r0_ready = 1'b0;
        r1_ready = 1'b0;
        add_a    = '0;
        add_b    = '0;
        add_cin  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Ready is suppressed while reset is held so no grant is
                // signalled for a request that the reset edge will discard.
                if (!rst && (r0_valid || r1_valid)) begin
                    r0_ready = !grant_r1;
                    r1_ready = grant_r1;
                    a_d      = grant_r1 ? r1_a    : r0_a;
                    b_d      = grant_r1 ? r1_b    : r0_b;
                    cin_d    = grant_r1 ? r1_cin  : r0_cin;
                    wide_d   = grant_r1 ? r1_wide : r0_wide;
                    id_d     = grant_r1;
                    ptr_d    = grant_r1;
                    state_d  = LO;
                end
            end
            LO: begin
                add_a              = a_q[WIDTH-1:0];
                add_b              = b_q[WIDTH-1:0];
                add_cin            = cin_q;
                sum_d[WIDTH-1:0]   = add_sum;
                carry_d            = add_cout;
                if (wide_q) begin
                    state_d = HI;
                end else begin
                    // Low pass is the most-significant one for a narrow add.
                    sum_d[2*WIDTH-1:WIDTH] = '0;
                    cout_d                 = add_cout;
                    of_d                   = add_of;
                    state_d                = RESP;
                end
            end
            HI: begin
                add_a                  = a_q[2*WIDTH-1:WIDTH];
                add_b                  = b_q[2*WIDTH-1:WIDTH];
                add_cin                = carry_q;
                sum_d[2*WIDTH-1:WIDTH] = add_sum;
                cout_d                 = add_cout;
                of_d                   = add_of;
                state_d                = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its _d value from before this edge.
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            wide_q  <= 1'b0;
            id_q    <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            of_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            wide_q  <= wide_d;
            id_q    <= id_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            of_q    <= of_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;
    assign rsp_of    = of_q;

endmodule
